if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 121 ++++++++++++
 tb/tb_if_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding memory request, single-entry instruction
// buffer, and redirect handling that drains an in-flight request before refetching.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] F_pc,
    output logic [31:0] F_instr,
    output logic        F_valid
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned INSN_LEN = 4;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        HOLD    = 2'b01,
        DISCARD = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic [XLEN-1:0]   ibuf_q, ibuf_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            ibuf_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            ibuf_q     <= ibuf_d;
        end
    end

    // Next-state logic; redirect outranks ack and enable in every state
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        ibuf_d     = ibuf_q;
        case (state_q)
            FETCH: begin
                // pc is stable while a request is open, so tracking it here
                // captures the address of the request actually on the bus
                req_addr_d = pc_q;
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = im_ack ? FETCH : DISCARD;
                end else if (im_ack) begin
                    ibuf_d  = im_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    ibuf_d  = '0;
                    state_d = FETCH;
                end else if (enable) begin
                    pc_d    = pc_q + XLEN'(INSN_LEN);
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (im_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Output decode; reset masks the request and the valid flag immediately
    always_comb begin
        im_req  = 1'b0;
        im_addr = {pc_q[XLEN-1:2], 2'b00};
        F_pc    = pc_q;
        F_instr = '0;
        F_valid = 1'b0;
        if (state_q == DISCARD) begin
            im_addr = {req_addr_q[XLEN-1:2], 2'b00};
        end
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    im_req = 1'b1;
                end
                HOLD: begin
                    F_valid = 1'b1;
                    F_instr = ibuf_q;
                end
                DISCARD: begin
                    im_req = 1'b1;
                end
                default: begin
                    im_req = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch: a program-order PC model predicts each
// presented instruction; protocol rules on the memory port are checked every cycle.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset, enable, redirect;
    logic [31:0] redirect_pc;
    logic        im_req, im_ack;
    logic [31:0] im_addr, im_rdata;
    logic [31:0] F_pc, F_instr;
    logic        F_valid;

    if_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ack      (im_ack),
        .im_rdata    (im_rdata),
        .F_pc        (F_pc),
        .F_instr     (F_instr),
        .F_valid     (F_valid)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    bit          ack_tied = 1'b1;
    logic [31:0] exp_q[$];

    // Instruction memory contents: a fixed scramble of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural order of presented PCs
    initial begin
        logic [31:0] model_pc;
        model_pc = RST_PC;
        forever begin
            @(posedge clk);
            if (reset) begin
                exp_q.delete();
                model_pc = RST_PC;
                exp_q.push_back(model_pc);
            end else if (redirect) begin
                exp_q.delete();
                model_pc = redirect_pc;
                exp_q.push_back(model_pc);
            end else if (F_valid && enable) begin
                model_pc = model_pc + 32'd4;
                exp_q.push_back(model_pc);
            end
        end
    end

    // Memory responder: random latency 0..4, or ack tied high during boot
    initial begin
        int dly;
        dly      = 0;
        im_ack   = 1'b0;
        im_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (ack_tied) begin
                im_ack   = 1'b1;
                im_rdata = mem_word(im_addr);
            end else if (!im_req) begin
                im_ack   = 1'b0;
                im_rdata = $urandom;
                if (reset) dly = $urandom_range(0, 4);
            end else if (dly == 0) begin
                im_ack   = 1'b1;
                im_rdata = mem_word(im_addr);
                dly      = $urandom_range(0, 4);
            end else begin
                im_ack   = 1'b0;
                im_rdata = $urandom;
                dly--;
            end
        end
    end

    // Monitor: pops the scoreboard on each new presentation, checks port rules
    initial begin
        bit          shown, prev_rst, prev_req, prev_ack;
        logic [31:0] prev_addr, held_e, e;
        int          since_rst, bubbles;
        shown = 1'b0; prev_rst = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
        prev_addr = '0; held_e = '0; since_rst = 0; bubbles = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_im_req",  32'(im_req),  32'd0);
                chk("rst_F_valid", 32'(F_valid), 32'd0);
                chk("rst_F_instr", F_instr,      32'd0);
                shown = 1'b0; bubbles = 0; since_rst = 0;
            end else begin
                since_rst++;
                if (prev_rst) begin
                    chk("post_rst_req",  32'(im_req), 32'd1);
                    chk("post_rst_addr", im_addr,     RST_PC);
                end
                if (prev_req && !prev_ack && !prev_rst) begin
                    chk("req_held",  32'(im_req), 32'd1);
                    chk("addr_held", im_addr,     prev_addr);
                end
                if (im_req) chk("addr_align", 32'(im_addr[1:0]), 32'd0);
                if (F_valid) begin
                    chk("no_req_in_hold", 32'(im_req), 32'd0);
                    if (!shown) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_present: F_pc %h with no instruction expected", F_pc);
                            held_e = F_pc;
                        end else begin
                            e = exp_q.pop_front();
                            chk("F_pc",    F_pc,    e);
                            chk("F_instr", F_instr, mem_word(e));
                            held_e = e;
                        end
                        shown = 1'b1;
                    end else begin
                        chk("stall_F_pc",    F_pc,    held_e);
                        chk("stall_F_instr", F_instr, mem_word(held_e));
                    end
                    bubbles = 0;
                end else begin
                    chk("bubble_F_instr", F_instr, 32'd0);
                    shown = 1'b0;
                    bubbles++;
                    if (bubbles > 60) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL watchdog: no instruction presented for %0d cycles", bubbles);
                        bubbles = 0;
                    end
                end
                if (ack_tied && since_rst <= 6) begin
                    chk("boot_F_valid", 32'(F_valid), 32'(since_rst[0] == 1'b0));
                    if (since_rst[0] == 1'b0)
                        chk("boot_F_pc", F_pc, RST_PC + 32'(4 * (since_rst / 2 - 1)));
                end
            end
            prev_rst  = reset;
            prev_req  = im_req;
            prev_ack  = im_ack;
            prev_addr = im_addr;
        end
    end

    // Stimulus: tied-ack boot sequence, then randomized stalls, redirects and resets
    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1 ack_tied = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            reset    = ($urandom_range(0, 149) == 0);
            enable   = ($urandom_range(0, 2) != 0);
            redirect = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'hFFFF_FFFC;
                1:       redirect_pc = $urandom;
                2:       redirect_pc = 32'h0000_3100;
                default: redirect_pc = RST_PC + (32'($urandom_range(0, 63)) << 2);
            endcase
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        redirect = 1'b0;
        enable   = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
